// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard and sequencing controller for the 5-stage MIPS core.
//
// Purpose:
//   Drives the front-end stalls, the D and E pipeline register flushes and the
//   D/E-stage forwarding selects. It also runs the syscall drain/service FSM,
//   which freezes the front end until the OS handshake completes. A saturating
//   counter of StallD cycles is kept for performance monitoring.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   RsD/RtD, RsE/RtE              source registers in D and E
//   WriteReg{E,M,W}, RegWrite{E,M,W}  destination register and write enable
//   MemtoRegE/M                   load in E / M
//   BranchD, JumpD, PCSrcD        control-flow info from D
//   sysE, SysAck                  syscall in E, service complete
//   StallF/StallD, FlushD/FlushE  pipeline register control (combinational)
//   ForwardAD/BD, ForwardAE/BE    forwarding selects (combinational)
//   SysReq, SysBusy               service request (registered), FSM not idle
//   StallCount                    saturating StallD cycle count
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  input  logic             sysE,
  input  logic             SysAck,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             SysReq,
  output logic             SysBusy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {IDLE, DRAIN, SERVICE} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       sysreq_nxt;
  logic       lwstall, brstall, sysstall, stall;

  // Hazard detection and forwarding. Register 0 is never a real dependency,
  // so every match is qualified by a nonzero source/destination.
  always_comb begin
    lwstall  = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    brstall  = BranchD &&
               ((RegWriteE && (WriteRegE != 5'd0) &&
                 ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                (MemtoRegM && (WriteRegM != 5'd0) &&
                 ((WriteRegM == RsD) || (WriteRegM == RtD))));
    // A syscall entering E stalls in that same cycle, before the FSM leaves IDLE.
    sysstall = ((state == IDLE) && sysE) || (state == DRAIN) || (state == SERVICE);
    stall    = lwstall || brstall || sysstall;

    StallF    = stall;
    StallD    = stall;
    FlushE    = stall;
    // A stalled branch keeps its slot in D, so it must not be flushed.
    FlushD    = (PCSrcD || JumpD) && !stall;
    ForwardAD = RegWriteM && (RsD != 5'd0) && (WriteRegM == RsD);
    ForwardBD = RegWriteM && (RtD != 5'd0) && (WriteRegM == RtD);

    ForwardAE = 2'b00;
    if (RegWriteM && (RsE != 5'd0) && (WriteRegM == RsE))      ForwardAE = 2'b10;
    else if (RegWriteW && (RsE != 5'd0) && (WriteRegW == RsE)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RtE != 5'd0) && (WriteRegM == RtE))      ForwardBE = 2'b10;
    else if (RegWriteW && (RtE != 5'd0) && (WriteRegW == RtE)) ForwardBE = 2'b01;

    // While reset is held, no stall and both D and E registers are cleared.
    if (reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  // Syscall FSM next state. SysReq is registered, so it is derived from the
  // next state: it rises on entry to SERVICE and drops on the acking edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (sysE) begin
        state_nxt = DRAIN;
        cnt_nxt   = DRAIN_LOAD;
      end
      DRAIN: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = SERVICE;
      end
      SERVICE: if (SysAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sysreq_nxt = (state_nxt == SERVICE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      SysReq     <= 1'b0;
      StallCount <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      SysReq <= sysreq_nxt;
      if (StallD && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + 1'b1;
    end
  end

  assign SysBusy = (state != IDLE);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. A second instance with a 3-bit counter
// shares all inputs and is used for the saturation scenario.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, JumpD, PCSrcD, sysE, SysAck;
  logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, SysReq, SysBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCount;
  logic s_StallF, s_StallD, s_FlushD, s_FlushE, s_ForwardAD, s_ForwardBD, s_SysReq, s_SysBusy;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [2:0] s_StallCount;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .JumpD(JumpD),
    .PCSrcD(PCSrcD), .sysE(sysE), .SysAck(SysAck), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .SysReq(SysReq), .SysBusy(SysBusy),
    .StallCount(StallCount));

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .JumpD(JumpD),
    .PCSrcD(PCSrcD), .sysE(sysE), .SysAck(SysAck), .StallF(s_StallF), .StallD(s_StallD),
    .FlushD(s_FlushD), .FlushE(s_FlushE), .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .SysReq(s_SysReq), .SysBusy(s_SysBusy),
    .StallCount(s_StallCount));

  task automatic clr;
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, JumpD, PCSrcD, sysE, SysAck} = '0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    clr();
    reset = 1'b1;
    RegWriteM = 1'b1; WriteRegM = 5'd5; RsE = 5'd5; RsD = 5'd5; PCSrcD = 1'b0;
    MemtoRegE = 1'b1; RtE = 5'd5;
    @(negedge clk);
    total++; if (StallF !== 1'b0 || StallD !== 1'b0) begin bad++; $display("FAIL rst_stall got F=%b D=%b want 0 0", StallF, StallD); end
    total++; if (FlushD !== 1'b1 || FlushE !== 1'b1) begin bad++; $display("FAIL rst_flush got D=%b E=%b want 1 1", FlushD, FlushE); end
    total++; if (ForwardAE !== 2'b00 || ForwardAD !== 1'b0) begin bad++; $display("FAIL rst_fwd got AE=%b AD=%b want 00 0", ForwardAE, ForwardAD); end
    tick();
    reset = 1'b0; clr();
    total++; if (SysReq !== 1'b0 || SysBusy !== 1'b0 || StallCount !== 16'd0) begin
      bad++; $display("FAIL rst_regs got req=%b busy=%b cnt=%0d want 0 0 0", SysReq, SysBusy, StallCount); end
  endtask

  task automatic test_forward;
    clr();
    RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd5; WriteRegW = 5'd5; RsE = 5'd5;
    RtE = 5'd7; RsD = 5'd5; RtD = 5'd6;
    @(negedge clk);
    total++; if (ForwardAE !== 2'b10) begin bad++; $display("FAIL fwd_m_prio got %b want 10", ForwardAE); end
    total++; if (ForwardBE !== 2'b00) begin bad++; $display("FAIL fwd_be_none got %b want 00", ForwardBE); end
    total++; if (ForwardAD !== 1'b1 || ForwardBD !== 1'b0) begin bad++; $display("FAIL fwd_d got AD=%b BD=%b want 1 0", ForwardAD, ForwardBD); end
    tick();
    RegWriteM = 1'b0; WriteRegW = 5'd7; RsE = 5'd7;
    @(negedge clk);
    total++; if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin bad++; $display("FAIL fwd_w got AE=%b BE=%b want 01 01", ForwardAE, ForwardBE); end
    tick();
    RegWriteM = 1'b1; WriteRegM = 5'd0; WriteRegW = 5'd0; RsE = 5'd0; RtE = 5'd0; RsD = 5'd0;
    @(negedge clk);
    total++; if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00 || ForwardAD !== 1'b0) begin
      bad++; $display("FAIL fwd_r0 got AE=%b BE=%b AD=%b want 00 00 0", ForwardAE, ForwardBE, ForwardAD); end
    tick();
  endtask

  task automatic test_load_use;
    clr();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; RtE = 5'd8; RsD = 5'd8; WriteRegE = 5'd8;
    @(negedge clk);
    total++; if (StallF !== 1'b1 || StallD !== 1'b1 || FlushE !== 1'b1) begin
      bad++; $display("FAIL lw_stall got F=%b D=%b FE=%b want 1 1 1", StallF, StallD, FlushE); end
    tick();
    // load has moved on; the consumer is now in E
    clr(); RsD = 5'd8;
    @(negedge clk);
    total++; if (StallD !== 1'b0 || FlushE !== 1'b0) begin bad++; $display("FAIL lw_once got D=%b FE=%b want 0 0", StallD, FlushE); end
    tick();
    MemtoRegE = 1'b1; RtE = 5'd0; RsD = 5'd0; RtD = 5'd0;
    @(negedge clk);
    total++; if (StallD !== 1'b0) begin bad++; $display("FAIL lw_r0 got %b want 0", StallD); end
    tick();
    // load-use together with a taken branch: stall wins, D not flushed
    clr(); MemtoRegE = 1'b1; RtE = 5'd4; RtD = 5'd4; PCSrcD = 1'b1;
    @(negedge clk);
    total++; if (StallD !== 1'b1 || FlushD !== 1'b0) begin bad++; $display("FAIL lw_pcsrc got D=%b FD=%b want 1 0", StallD, FlushD); end
    tick();
  endtask

  task automatic test_branch;
    clr();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3; PCSrcD = 1'b1;
    @(negedge clk);
    total++; if (StallD !== 1'b1 || FlushD !== 1'b0 || FlushE !== 1'b1) begin
      bad++; $display("FAIL br_stall got D=%b FD=%b FE=%b want 1 0 1", StallD, FlushD, FlushE); end
    tick();
    RegWriteE = 1'b0;
    @(negedge clk);
    total++; if (StallD !== 1'b0 || FlushD !== 1'b1) begin bad++; $display("FAIL br_taken got D=%b FD=%b want 0 1", StallD, FlushD); end
    tick();
    clr(); BranchD = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd9; RsD = 5'd9;
    @(negedge clk);
    total++; if (StallD !== 1'b1) begin bad++; $display("FAIL br_loadm got %b want 1", StallD); end
    tick();
    clr(); JumpD = 1'b1;
    @(negedge clk);
    total++; if (FlushD !== 1'b1 || StallF !== 1'b0) begin bad++; $display("FAIL jump got FD=%b F=%b want 1 0", FlushD, StallF); end
    tick();
  endtask

  task automatic test_syscall;
    // cycle 0: syscall together with a branch hazard
    clr(); sysE = 1'b1; BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3;
    @(negedge clk);
    total++; if (StallD !== 1'b1 || FlushE !== 1'b1 || SysBusy !== 1'b0) begin
      bad++; $display("FAIL sys_c0 got D=%b FE=%b busy=%b want 1 1 0", StallD, FlushE, SysBusy); end
    tick();
    // cycle 1: DRAIN; an ack here must be ignored
    clr(); SysAck = 1'b1;
    @(negedge clk);
    total++; if (SysBusy !== 1'b1 || StallD !== 1'b1 || SysReq !== 1'b0) begin
      bad++; $display("FAIL sys_c1 got busy=%b D=%b req=%b want 1 1 0", SysBusy, StallD, SysReq); end
    tick();
    SysAck = 1'b0;
    @(negedge clk);
    total++; if (StallD !== 1'b1 || SysReq !== 1'b0) begin bad++; $display("FAIL sys_c2 got D=%b req=%b want 1 0", StallD, SysReq); end
    tick();
    @(negedge clk);
    total++; if (SysReq !== 1'b1 || StallD !== 1'b1) begin bad++; $display("FAIL sys_c3 got req=%b D=%b want 1 1", SysReq, StallD); end
    tick();
    @(negedge clk);
    total++; if (SysReq !== 1'b1 || StallF !== 1'b1) begin bad++; $display("FAIL sys_c4 got req=%b F=%b want 1 1", SysReq, StallF); end
    tick();
    SysAck = 1'b1;
    @(negedge clk);
    total++; if (SysReq !== 1'b1 || StallD !== 1'b1) begin bad++; $display("FAIL sys_c5 got req=%b D=%b want 1 1", SysReq, StallD); end
    tick();
    SysAck = 1'b0;
    @(negedge clk);
    total++; if (SysReq !== 1'b0 || SysBusy !== 1'b0 || StallD !== 1'b0) begin
      bad++; $display("FAIL sys_c6 got req=%b busy=%b D=%b want 0 0 0", SysReq, SysBusy, StallD); end
    total++; if (StallCount !== 16'd6) begin bad++; $display("FAIL sys_cnt got %0d want 6", StallCount); end
    tick();
  endtask

  task automatic test_reset_service;
    clr(); sysE = 1'b1;
    tick(); clr();
    tick(); tick(); // now in SERVICE
    @(negedge clk);
    total++; if (SysReq !== 1'b1) begin bad++; $display("FAIL rsv_pre got req=%b want 1", SysReq); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (FlushD !== 1'b1 || FlushE !== 1'b1 || StallF !== 1'b0) begin
      bad++; $display("FAIL rsv_comb got FD=%b FE=%b F=%b want 1 1 0", FlushD, FlushE, StallF); end
    tick();
    reset = 1'b0;
    total++; if (SysReq !== 1'b0 || SysBusy !== 1'b0 || StallCount !== 16'd0) begin
      bad++; $display("FAIL rsv_post got req=%b busy=%b cnt=%0d want 0 0 0", SysReq, SysBusy, StallCount); end
    tick(); tick(); tick();
    total++; if (SysReq !== 1'b0 || StallD !== 1'b0) begin bad++; $display("FAIL rsv_noreq got req=%b D=%b want 0 0", SysReq, StallD); end
  endtask

  task automatic test_saturation;
    clr(); reset = 1'b1; tick(); reset = 1'b0;
    MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
    for (int i = 0; i < 10; i++) tick();
    total++; if (s_StallCount !== 3'd7) begin bad++; $display("FAIL sat_small got %0d want 7", s_StallCount); end
    total++; if (StallCount !== 16'd10) begin bad++; $display("FAIL sat_wide got %0d want 10", StallCount); end
    tick();
    total++; if (s_StallCount !== 3'd7 || StallCount !== 16'd11) begin
      bad++; $display("FAIL sat_hold got small=%0d wide=%0d want 7 11", s_StallCount, StallCount); end
    clr(); tick();
    total++; if (StallCount !== 16'd11) begin bad++; $display("FAIL cnt_idle got %0d want 11", StallCount); end
  endtask

  initial begin
    clr(); reset = 1'b1;
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    // restart the counter so the syscall stall total is exact
    reset = 1'b1; tick(); reset = 1'b0;
    test_syscall();
    test_reset_service();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
